jtframe_rom_sched: RTL and testbench

Four-slot SDRAM ROM read scheduler between game-side ROM requesters (main CPU, sound CPU, scroll/char/object fetchers) and the single framework SDRAM read port (`sdram_req`/`sdram_addr`/`sdram_ack`/`data_rdy`/`data_read`). It arbitrates misses, holds one cached 32-bit word per slot so repeated reads hit without SDRAM traffic, and drives `refresh_en` when idle. It sits inside each `*_game` module, below the requesters and above the framework's SDRAM controller.

---
 rtl/jtframe_rom_sched.sv | 169 ++++++++++++++++
 tb/tb_jtframe_rom_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_rom_sched.sv
// Four-slot SDRAM ROM read scheduler with a one-word cache per slot.
// Optional build macro JTFRAME_ROMSCHED_RR_EN selects round-robin arbitration;
// without it slot 0 has the highest priority and slot 3 the lowest.
module jtframe_rom_sched #(
  parameter int unsigned AW      = 22,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [3:0]        slot_cs,
  input  logic [4*AW-1:0]   slot_addr,
  output logic [3:0]        slot_ok,
  output logic [4*32-1:0]   slot_dout,
  output logic              sdram_req,
  output logic [AW-1:0]     sdram_addr,
  input  logic              sdram_ack,
  input  logic              data_rdy,
  input  logic [31:0]       data_read,
  output logic              refresh_en
);

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t          state_q;
  logic [1:0]      gnt_q;
  logic [CW-1:0]   cnt_q;
  logic [NS-1:0]   valid_q;
  logic [AW-1:0]   tag_q  [NS];
  logic [DW-1:0]   data_q [NS];

  logic [AW-1:0]   addr_a [NS];
  logic [NS-1:0]   hit;
  logic [NS-1:0]   miss;
  logic [1:0]      win;
  logic            win_vld;

`ifdef JTFRAME_ROMSCHED_RR_EN
  logic [1:0]      rr_ptr;
  logic [1:0]      rr_idx;
`endif

  // Unpack slot addresses and evaluate per-slot hit/miss against the cache
  always_comb begin
    hit  = '0;
    miss = '0;
    for (int n = 0; n < NS; n++) begin
      addr_a[n] = slot_addr[n*AW +: AW];
      hit[n]    = valid_q[n] && (tag_q[n] == addr_a[n]);
      miss[n]   = slot_cs[n] && !hit[n];
    end
  end

  // Cached words are always visible; ok only for a live hit outside download
  always_comb begin
    for (int n = 0; n < NS; n++) begin
      slot_dout[n*DW +: DW] = data_q[n];
    end
    slot_ok    = slot_cs & hit & {NS{~downloading}};
    refresh_en = (state_q == ST_IDLE) && (miss == '0);
  end

  // Pick the slot to serve next among the missing ones
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
`ifdef JTFRAME_ROMSCHED_RR_EN
    rr_idx  = '0;
    // scan backwards so the slot closest to the pointer is the last to win
    for (int i = NS - 1; i >= 0; i--) begin
      rr_idx = rr_ptr + 2'(i);
      if (miss[rr_idx]) begin
        win     = rr_idx;
        win_vld = 1'b1;
      end
    end
`else
    for (int i = NS - 1; i >= 0; i--) begin
      if (miss[i]) begin
        win     = 2'(i);
        win_vld = 1'b1;
      end
    end
`endif
  end

  // Scheduler FSM: grant, request, wait for data, fill the slot cache
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      for (int n = 0; n < NS; n++) begin
        tag_q[n]  <= '0;
        data_q[n] <= '0;
      end
`ifdef JTFRAME_ROMSCHED_RR_EN
      rr_ptr     <= '0;
`endif
    end else if (downloading) begin
      // ROM contents are changing: abort and forget everything cached
      state_q   <= ST_IDLE;
      sdram_req <= 1'b0;
      valid_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            gnt_q      <= win;
            sdram_addr <= addr_a[win];
            sdram_req  <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            cnt_q     <= '0;
            if (data_rdy) begin
              // ack and data together: finish the fill right away
              data_q[gnt_q]  <= data_read;
              tag_q[gnt_q]   <= sdram_addr;
              valid_q[gnt_q] <= 1'b1;
              state_q        <= ST_IDLE;
`ifdef JTFRAME_ROMSCHED_RR_EN
              rr_ptr         <= gnt_q + 2'd1;
`endif
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (data_rdy) begin
            // tag with the fetched address even if the requester moved on
            data_q[gnt_q]  <= data_read;
            tag_q[gnt_q]   <= sdram_addr;
            valid_q[gnt_q] <= 1'b1;
            state_q        <= ST_IDLE;
`ifdef JTFRAME_ROMSCHED_RR_EN
            rr_ptr         <= gnt_q + 2'd1;
`endif
          end else if (cnt_q == CW'(TIMEOUT)) begin
            // give up; the slot still misses and will be granted again
            state_q <= ST_IDLE;
`ifdef JTFRAME_ROMSCHED_RR_EN
            rr_ptr  <= gnt_q + 2'd1;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_rom_sched.sv
// Directed bench for jtframe_rom_sched: reset, miss/hit, contention, timeout,
// download abort and simultaneous ack+data. Order expectations follow the
// JTFRAME_ROMSCHED_RR_EN build macro.
module tb_jtframe_rom_sched;

  localparam int unsigned AW = 22;

  logic            clk;
  logic            rst_n;
  logic            downloading;
  logic [3:0]      slot_cs;
  logic [4*AW-1:0] slot_addr;
  logic [3:0]      slot_ok;
  logic [127:0]    slot_dout;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_ack;
  logic            data_rdy;
  logic [31:0]     data_read;
  logic            refresh_en;

  int n_chk  = 0;
  int n_pass = 0;

  jtframe_rom_sched #(.AW(AW), .TIMEOUT(63)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .refresh_en  (refresh_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int n, input logic [AW-1:0] a);
    slot_addr[n*AW +: AW] = a;
  endtask

  function automatic logic [31:0] dout(input int n);
    return slot_dout[n*32 +: 32];
  endfunction

  function automatic logic [31:0] word_for(input logic [AW-1:0] a);
    return 32'hC0DE_0000 + 32'(a);
  endfunction

  task automatic pulse_ack();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
  endtask

  task automatic pulse_rdy(input logic [31:0] d);
    data_rdy  = 1'b1;
    data_read = d;
    tick();
    data_rdy  = 1'b0;
  endtask

  task automatic pulse_both(input logic [31:0] d);
    sdram_ack = 1'b1;
    data_rdy  = 1'b1;
    data_read = d;
    tick();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
  endtask

  // Serve the current request: ack, one wait cycle, data tagged by address
  task automatic serve();
    logic [AW-1:0] a;
    a = sdram_addr;
    pulse_ack();
    tick();
    pulse_rdy(word_for(a));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first, second, dl_first;
    logic [AW-1:0] a0, a3;
    logic bad, got;

`ifdef JTFRAME_ROMSCHED_RR_EN
    first = 3; second = 0; dl_first = 3;
`else
    first = 0; second = 3; dl_first = 0;
`endif

    rst_n = 1'b0; downloading = 1'b0; slot_cs = '0; slot_addr = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",     64'(sdram_req),  64'd0);
    check("rst_addr",    64'(sdram_addr), 64'd0);
    check("rst_ok",      64'(slot_ok),    64'd0);
    check("rst_dout_lo", slot_dout[63:0], 64'd0);
    check("rst_refresh", 64'(refresh_en), 64'd1);
    rst_n = 1'b1;
    tick();

    // single miss on slot 1
    set_addr(1, 22'h012345);
    slot_cs = 4'b0010;
    #1;
    check("miss_ok0",      64'(slot_ok),    64'd0);
    check("miss_refresh0", 64'(refresh_en), 64'd0);
    tick();
    check("miss_req",  64'(sdram_req),  64'd1);
    check("miss_addr", 64'(sdram_addr), 64'h012345);
    tick(); tick();
    pulse_ack();
    check("miss_req_drop", 64'(sdram_req), 64'd0);
    repeat (4) tick();
    check("miss_ok_wait", 64'(slot_ok),    64'd0);
    check("miss_addr_hold", 64'(sdram_addr), 64'h012345);
    pulse_rdy(32'hDEADBEEF);
    check("miss_ok1",     64'(slot_ok),    64'b0010);
    check("miss_dout1",   64'(dout(1)),    64'hDEADBEEF);
    check("miss_refresh", 64'(refresh_en), 64'd1);

    // re-request the cached word: same-cycle hit, no SDRAM traffic
    slot_cs = '0;
    tick();
    slot_cs = 4'b0010;
    #1;
    check("hit_ok",  64'(slot_ok), 64'b0010);
    tick();
    check("hit_noreq", 64'(sdram_req), 64'd0);
    slot_cs = '0;
    tick();

    // contention between slots 0 and 3, two rounds
    for (int r = 0; r < 2; r++) begin
      a0 = 22'h000100 + 22'(4 * r);
      a3 = 22'h000300 + 22'(4 * r);
      set_addr(0, a0);
      set_addr(3, a3);
      slot_cs = 4'b1001;
      tick();
      check($sformatf("cont%0d_first", r), 64'(sdram_addr), 64'(first == 0 ? a0 : a3));
      serve();
      check($sformatf("cont%0d_ok1", r), 64'(slot_ok), 64'(first == 0 ? 4'b0001 : 4'b1000));
      tick();
      check($sformatf("cont%0d_second", r), 64'(sdram_addr), 64'(second == 0 ? a0 : a3));
      serve();
      check($sformatf("cont%0d_ok2", r), 64'(slot_ok), 64'b1001);
      check($sformatf("cont%0d_d0", r), 64'(dout(0)), 64'(word_for(a0)));
      check($sformatf("cont%0d_d3", r), 64'(dout(3)), 64'(word_for(a3)));
    end
    slot_cs = '0;
    tick();

    // timeout: data withheld after ack, retry for the same slot
    set_addr(2, 22'h000222);
    slot_cs = 4'b0100;
    tick();
    check("to_req",  64'(sdram_req),  64'd1);
    check("to_addr", 64'(sdram_addr), 64'h000222);
    pulse_ack();
    bad = 1'b0;
    repeat (60) begin
      tick();
      if (sdram_req) bad = 1'b1;
    end
    check("to_quiet", 64'(bad), 64'd0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sdram_req) begin
        got = 1'b1;
        break;
      end
    end
    check("to_retry",      64'(got),        64'd1);
    check("to_retry_addr", 64'(sdram_addr), 64'h000222);
    check("to_ok0",        64'(slot_ok),    64'd0);
    // simultaneous ack and data completes the fill directly
    pulse_both(32'h2222_BEEF);
    check("both_ok",   64'(slot_ok),  64'b0100);
    check("both_dout", 64'(dout(2)),  64'h2222_BEEF);
    check("both_req",  64'(sdram_req), 64'd0);
    slot_cs = '0;
    tick();

    // download during REQ aborts and invalidates
    slot_cs = 4'b0001;
    #1;
    check("dl_hit", 64'(slot_ok), 64'b0001);
    set_addr(3, 22'h000333);
    slot_cs = 4'b1001;
    tick();
    check("dl_req",  64'(sdram_req),  64'd1);
    check("dl_addr", 64'(sdram_addr), 64'h000333);
    downloading = 1'b1;
    #1;
    check("dl_ok_now", 64'(slot_ok), 64'd0);
    tick();
    check("dl_req_drop", 64'(sdram_req), 64'd0);
    tick(); tick();
    check("dl_nogrant", 64'(sdram_req), 64'd0);
    downloading = 1'b0;
    #1;
    check("dl_ok_after", 64'(slot_ok), 64'd0);
    tick();
    check("dl_refetch_req",  64'(sdram_req), 64'd1);
    check("dl_refetch_addr", 64'(sdram_addr), 64'(dl_first == 0 ? 22'h000104 : 22'h000333));
    serve();
    tick();
    serve();
    check("dl_ok_final", 64'(slot_ok), 64'b1001);
    check("dl_d3",       64'(dout(3)), 64'(word_for(22'h000333)));
    slot_cs = '0;
    tick();

    // asynchronous reset in the middle of WAIT
    set_addr(1, 22'h000055);
    slot_cs = 4'b0010;
    tick();
    pulse_ack();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",  64'(sdram_req),  64'd0);
    check("arst_addr", 64'(sdram_addr), 64'd0);
    check("arst_ok",   64'(slot_ok),    64'd0);
    check("arst_dout", slot_dout[127:64], 64'd0);
    slot_cs = '0;
    #1;
    check("arst_refresh", 64'(refresh_en), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_refresh", 64'(refresh_en), 64'd1);
    check("post_ok",      64'(slot_ok),    64'd0);
    check("post_req",     64'(sdram_req),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
